// File: rtl/bp_fe_cmd_queue.sv
// Front-end command queue: in-order FIFO between the back end and the FE controller.
// Attaboy hints arriving while full are accepted and discarded, with a saturating drop count.

package bp_fe_cmd_queue_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg = 2'd0,
        e_bp_small_cfg   = 2'd1
    } bp_params_e;

    typedef enum logic [2:0] {
        e_op_state_reset          = 3'd0,
        e_op_pc_redirection       = 3'd1,
        e_op_icache_fill_response = 3'd2,
        e_op_icache_fence         = 3'd3,
        e_op_attaboy              = 3'd4,
        e_op_wait                 = 3'd5
    } bp_fe_command_queue_opcodes_e;

    localparam int vaddr_width_gp = 39;

    typedef struct packed {
        bp_fe_command_queue_opcodes_e opcode;
        logic [vaddr_width_gp-1:0]    npc;
        logic [15:0]                  operands;
    } bp_fe_cmd_s;

    // Every supported configuration currently shares one command layout.
    function automatic int fe_cmd_width_f(input bp_params_e cfg);
        case (cfg)
            e_bp_small_cfg: return $bits(bp_fe_cmd_s);
            default:        return $bits(bp_fe_cmd_s);
        endcase
    endfunction

endpackage

module bp_fe_cmd_queue
    import bp_fe_cmd_queue_pkg::*;
#(
    parameter bp_params_e bp_params_p      = e_bp_default_cfg,
    parameter int         els_p            = 4,
    parameter int         drop_cnt_width_p = 16,
    localparam int        fe_cmd_width_lp  = fe_cmd_width_f(bp_params_p),
    localparam int        count_width_lp   = $clog2(els_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic [fe_cmd_width_lp-1:0]  fe_cmd_i,
    input  logic                        fe_cmd_v_i,
    output logic                        fe_cmd_ready_and_o,

    output logic [fe_cmd_width_lp-1:0]  fe_cmd_o,
    output logic                        fe_cmd_v_o,
    input  logic                        fe_cmd_yumi_i,

    output logic [count_width_lp-1:0]   count_o,
    output logic                        attaboy_drop_o,
    output logic [drop_cnt_width_p-1:0] attaboy_drops_o
);

    localparam int idx_width_lp = $clog2(els_p);
    localparam int ptr_width_lp = idx_width_lp + 1;

    bp_fe_cmd_s                  mem [els_p];
    bp_fe_cmd_s                  cmd_in;
    logic [ptr_width_lp-1:0]     wptr;
    logic [ptr_width_lp-1:0]     rptr;
    logic [drop_cnt_width_p-1:0] drops;

    logic full;
    logic empty;
    logic is_attaboy_in;
    logic enq;
    logic drop;

    assign cmd_in        = bp_fe_cmd_s'(fe_cmd_i);
    assign is_attaboy_in = (cmd_in.opcode == e_op_attaboy);

    // Wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[idx_width_lp] != rptr[idx_width_lp])
                && (wptr[idx_width_lp-1:0] == rptr[idx_width_lp-1:0]);

    assign fe_cmd_ready_and_o = ~full | is_attaboy_in;
    assign enq                = fe_cmd_v_i & ~full;
    assign drop               = fe_cmd_v_i & full & is_attaboy_in;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr  <= '0;
            rptr  <= '0;
            drops <= '0;
        end else begin
            if (enq) begin
                wptr <= wptr + 1'b1;
            end
            if (fe_cmd_yumi_i) begin
                rptr <= rptr + 1'b1;
            end
            if (drop && !(&drops)) begin
                drops <= drops + 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset; the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (enq && !reset_i) begin
            mem[wptr[idx_width_lp-1:0]] <= cmd_in;
        end
    end

    assign fe_cmd_o        = mem[rptr[idx_width_lp-1:0]];
    assign fe_cmd_v_o      = ~empty;
    assign count_o         = wptr - rptr;
    assign attaboy_drop_o  = drop;
    assign attaboy_drops_o = drops;

endmodule
